// File: rtl/prog_timer_pkg.sv
// Shared types for the programmable timer: write-target select and channel mode.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package prog_timer_pkg;

  // Register write targets carried on wr_sel
  typedef enum logic [1:0] {
    CMP     = 2'd0,
    CTRL    = 2'd1,
    IRQ_CLR = 2'd2,
    PSC     = 2'd3
  } wr_sel_e;

  // Channel behaviour on a compare match
  typedef enum logic {
    PERIODIC = 1'b0,
    ONESHOT  = 1'b1
  } mode_e;

  // Bit positions inside a CTRL write
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_BIT = 1;

  // Channel-index width; a single channel still gets a 1-bit select
  function automatic int unsigned ch_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prog_timer_channel.sv
// One timer channel: up-counter advanced by the shared tick, compare match, sticky pending flag.
// Latency: match sets pending on the edge that ends the tick cycle; pending is a register.
// Backpressure: none; register writes are accepted every cycle they are strobed.
module timer_channel
  import prog_timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             cmp_we_i,
  input  logic             ctrl_we_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] count_o,
  output logic             pending_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] cmp_q, cmp_d;
  logic             en_q, en_d;
  mode_e            mode_q, mode_d;
  logic             pend_q, pend_d;
  logic             match;

  // Next-state: count/match on tick, then register writes override count and enable
  always_comb begin
    count_d = count_q;
    cmp_d   = cmp_q;
    en_d    = en_q;
    mode_d  = mode_q;
    pend_d  = pend_q;
    match   = tick_i && en_q && (count_q == cmp_q);

    if (tick_i && en_q) begin
      if (match) begin
        count_d = '0;
        if (mode_q == ONESHOT) begin
          en_d = 1'b0;
        end
      end else begin
        // Natural wrap at 2^WIDTH lets a counter that overshot a lowered cmp come back round
        count_d = count_q + WIDTH'(1);
      end
    end

    // Compare value changes never disturb the running count
    if (cmp_we_i) begin
      cmp_d = data_i;
    end

    // A CTRL write restarts the channel from zero with the new enable/mode
    if (ctrl_we_i) begin
      en_d    = data_i[CTRL_EN_BIT];
      mode_d  = mode_e'(data_i[CTRL_MODE_BIT]);
      count_d = '0;
    end

    // Clear is applied first so a simultaneous match keeps the flag set
    if (clr_i) begin
      pend_d = 1'b0;
    end
    if (match) begin
      pend_d = 1'b1;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      cmp_q   <= '0;
      en_q    <= 1'b0;
      mode_q  <= PERIODIC;
      pend_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      cmp_q   <= cmp_d;
      en_q    <= en_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
    end
  end

  assign count_o   = count_q;
  assign pending_o = pend_q;

endmodule

// File: rtl/prog_timer.sv
// Multi-channel programmable timer with a shared prescaler and per-channel sticky interrupts.
// Latency: irq rises one edge after the matching tick cycle; rd_count is combinational.
// Backpressure: none; one register write per wr_en cycle, always accepted.
module prog_timer
  import prog_timer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int PSC_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [1:0]              wr_sel,
  input  logic [ch_w(NCH)-1:0]    wr_ch,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic [ch_w(NCH)-1:0]    rd_ch,
  output logic [WIDTH-1:0]        rd_count,
  output logic [NCH-1:0]          irq,
  output logic                    irq_any
);

  wr_sel_e          sel;
  logic [PSC_W-1:0] psc_div_q, psc_div_d;
  logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;
  logic             tick;
  logic [WIDTH-1:0] cnt_arr [NCH];
  logic [NCH-1:0]   pend;

  assign sel = wr_sel_e'(wr_sel);

  // Prescaler: tick on the cycle the counter equals the divisor; a PSC write restarts it
  always_comb begin
    psc_div_d = psc_div_q;
    tick      = (psc_cnt_q == psc_div_q);
    psc_cnt_d = tick ? '0 : psc_cnt_q + PSC_W'(1);
    if (wr_en && sel == PSC) begin
      psc_div_d = PSC_W'(wr_data);
      psc_cnt_d = '0;
    end
  end

  // Prescaler registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      psc_div_q <= '0;
      psc_cnt_q <= '0;
    end else begin
      psc_div_q <= psc_div_d;
      psc_cnt_q <= psc_cnt_d;
    end
  end

  // Channels only decode their own index, so out-of-range wr_ch hits nothing
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic hit;
    assign hit = wr_en && (int'(wr_ch) == g);

    timer_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .tick_i    (tick),
      .cmp_we_i  (hit && sel == CMP),
      .ctrl_we_i (hit && sel == CTRL),
      .clr_i     (hit && sel == IRQ_CLR),
      .data_i    (wr_data),
      .count_o   (cnt_arr[g]),
      .pending_o (pend[g])
    );
  end

  // Read mux; an unpopulated channel index reads as zero
  always_comb begin
    rd_count = '0;
    for (int i = 0; i < NCH; i++) begin
      if (int'(rd_ch) == i) begin
        rd_count = cnt_arr[i];
      end
    end
  end

  assign irq     = pend;
  assign irq_any = |pend;

endmodule

// File: tb/tb_prog_timer.sv
// Directed bench for prog_timer with hand-computed expectations.
// Small WIDTH/NCH so wrap-around and out-of-range channel writes are reachable.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_prog_timer;
  localparam int WIDTH = 4;
  localparam int NCH   = 3;
  localparam int PSC_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [1:0]       wr_sel;
  logic [1:0]       wr_ch;
  logic [WIDTH-1:0] wr_data;
  logic [1:0]       rd_ch;
  logic [WIDTH-1:0] rd_count;
  logic [NCH-1:0]   irq;
  logic             irq_any;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  prog_timer #(.WIDTH(WIDTH), .NCH(NCH), .PSC_W(PSC_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_ch    (wr_ch),
    .wr_data  (wr_data),
    .rd_ch    (rd_ch),
    .rd_count (rd_count),
    .irq      (irq),
    .irq_any  (irq_any)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] sel, input logic [1:0] ch, input logic [WIDTH-1:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_ch   = ch;
    wr_data = data;
    step();
    wr_en   = 1'b0;
    wr_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic check_cnt(input string tag, input logic [1:0] ch, input logic [31:0] exp);
    rd_ch = ch;
    #1;
    check_eq(tag, 32'(rd_count), exp);
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_sel  = 2'd0;
    wr_ch   = 2'd0;
    wr_data = '0;
    rd_ch   = 2'd0;
    step();
    rst = 1'b0;

    // Reset state
    check_eq("rst_irq", 32'(irq), 0);
    check_eq("rst_irq_any", 32'(irq_any), 0);
    check_cnt("rst_cnt0", 2'd0, 0);

    // psc=0, ch0 cmp=3 periodic: count 0,1,2,3 then match
    wr(2'd0, 2'd0, 4'd3);
    wr(2'd1, 2'd0, 4'd1);
    check_cnt("per_cnt_start", 2'd0, 0);
    for (int k = 1; k <= 3; k++) begin
      step();
      check_cnt("per_cnt_run", 2'd0, 32'(k));
      check_eq("per_irq_low", 32'(irq[0]), 0);
    end
    step();
    check_cnt("per_cnt_wrap", 2'd0, 0);
    check_eq("per_irq_rise", 32'(irq[0]), 1);
    check_eq("per_irq_any", 32'(irq_any), 1);
    wr(2'd2, 2'd0, '0);
    check_eq("per_irq_clr", 32'(irq[0]), 0);
    step(2);
    check_cnt("per_cnt_again", 2'd0, 3);
    check_eq("per_irq_still_low", 32'(irq[0]), 0);
    step();
    check_eq("per_irq_second", 32'(irq[0]), 1);

    // psc=2, ch1 cmp=1 one-shot: prescaler phase aligned so match lands 6 cycles after enable
    do_reset();
    wr(2'd3, 2'd0, 4'd2);
    wr(2'd0, 2'd1, 4'd1);
    step();
    wr(2'd1, 2'd1, 4'd3);
    for (int k = 1; k <= 5; k++) begin
      step();
      check_eq("os_irq_low", 32'(irq[1]), 0);
      if (k == 3) check_cnt("os_cnt_mid", 2'd1, 1);
    end
    step();
    check_eq("os_irq_rise", 32'(irq[1]), 1);
    check_cnt("os_cnt_zero", 2'd1, 0);
    wr(2'd2, 2'd1, '0);
    step(8);
    check_eq("os_no_rematch", 32'(irq[1]), 0);
    check_cnt("os_cnt_hold", 2'd1, 0);
    check_cnt("os_ch0_idle", 2'd0, 0);

    // Lower cmp below the running count: wrap 15 -> 0, then match at 5
    do_reset();
    wr(2'd0, 2'd0, 4'd12);
    wr(2'd1, 2'd0, 4'd1);
    step(10);
    check_cnt("wrap_cnt10", 2'd0, 10);
    wr(2'd0, 2'd0, 4'd5);
    check_cnt("wrap_cnt11", 2'd0, 11);
    step(4);
    check_cnt("wrap_cnt15", 2'd0, 15);
    step();
    check_cnt("wrap_cnt0", 2'd0, 0);
    step(5);
    check_cnt("wrap_cnt5", 2'd0, 5);
    check_eq("wrap_irq_low", 32'(irq[0]), 0);
    step();
    check_cnt("wrap_match_cnt", 2'd0, 0);
    check_eq("wrap_irq_rise", 32'(irq[0]), 1);

    // Clear colliding with a match on ch2; then a plain clear; then an out-of-range write
    do_reset();
    wr(2'd0, 2'd2, 4'd2);
    wr(2'd1, 2'd2, 4'd1);
    step(2);
    check_cnt("clr_cnt2", 2'd2, 2);
    wr(2'd2, 2'd2, '0);
    check_eq("clr_set_wins", 32'(irq[2]), 1);
    wr(2'd2, 2'd2, '0);
    check_eq("clr_next", 32'(irq[2]), 0);
    check_cnt("clr_cnt1", 2'd2, 1);
    wr(2'd1, 2'd3, 4'd0);
    check_cnt("oor_ch2_untouched", 2'd2, 2);
    check_eq("oor_irq", 32'(irq), 0);

    // All channels, distinct cmp, staggered enables
    do_reset();
    wr(2'd0, 2'd0, 4'd1);
    wr(2'd0, 2'd1, 4'd2);
    wr(2'd0, 2'd2, 4'd4);
    wr(2'd1, 2'd0, 4'd1);
    wr(2'd1, 2'd1, 4'd1);
    wr(2'd1, 2'd2, 4'd1);
    check_eq("all_irq_e2", 32'(irq), 32'b001);
    step();
    check_eq("all_irq_e3", 32'(irq), 32'b001);
    step();
    check_eq("all_irq_e4", 32'(irq), 32'b011);
    step(2);
    check_eq("all_irq_e6", 32'(irq), 32'b011);
    step();
    check_eq("all_irq_e7", 32'(irq), 32'b111);
    check_eq("all_irq_any", 32'(irq_any), 1);
    check_cnt("all_cnt0", 2'd0, 1);
    check_cnt("all_cnt1", 2'd1, 0);
    check_cnt("all_cnt2", 2'd2, 0);

    // Reset mid-run with a concurrent CTRL write: reset must win
    rst     = 1'b1;
    wr_en   = 1'b1;
    wr_sel  = 2'd1;
    wr_ch   = 2'd0;
    wr_data = 4'd1;
    step();
    rst     = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    check_eq("mid_rst_irq", 32'(irq), 0);
    check_eq("mid_rst_irq_any", 32'(irq_any), 0);
    check_cnt("mid_rst_cnt0", 2'd0, 0);
    check_cnt("mid_rst_cnt1", 2'd1, 0);
    check_cnt("mid_rst_cnt2", 2'd2, 0);
    step(3);
    check_cnt("mid_rst_no_run", 2'd0, 0);
    check_eq("mid_rst_irq_after", 32'(irq), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_timer.md
PROG_TIMER -- requirements
Module: prog_timer

Interface
REQ-001 Parameter WIDTH, default 16, counter/compare width per channel.
REQ-002 Parameter NCH, default 4, number of independent timer channels (1..16).
REQ-003 Parameter PSC_W, default 8, prescaler divisor width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 wr_en  input  1  register write strobe, one write per asserted cycle.
REQ-007 wr_sel  input  2  write target: CMP=0, CTRL=1, IRQ_CLR=2, PSC=3.
REQ-008 wr_ch  input  $clog2(NCH) (min 1)  target channel; ignored for PSC.
REQ-009 wr_data  input  WIDTH  write data; CTRL uses bit0=enable, bit1=mode (0 periodic, 1 one-shot); PSC uses bits [PSC_W-1:0]; IRQ_CLR ignores data.
REQ-010 rd_ch  input  $clog2(NCH) (min 1)  channel select for rd_count.
REQ-011 rd_count  output  WIDTH  combinational count of channel rd_ch.
REQ-012 irq  output  NCH  per-channel sticky pending flags, registered.
REQ-013 irq_any  output  1  OR-reduction of irq.

Function
REQ-014 Shared prescaler counter increments each cycle, emits tick for one cycle when equal to psc_div, then returns to 0; psc_div=0 yields tick every cycle.
REQ-015 Write to PSC loads psc_div and clears prescaler counter to 0 in the same edge.
REQ-016 Channel counts only on tick while enable=1; disabled channel holds count.
REQ-017 On tick with enable=1: count==cmp -> count<=0 and pending<=1 next edge; else count<=count+1 modulo 2^WIDTH.
REQ-018 Match period = (cmp+1)*(psc_div+1) clk cycles; cmp=0 matches every tick.
REQ-019 One-shot mode: match additionally clears enable in the same edge; periodic mode keeps enable.
REQ-020 Write to CTRL loads enable/mode and clears count to 0 in the same edge.
REQ-021 Write to CMP loads cmp without touching count; if new cmp < count, counter continues up, wraps 2^WIDTH-1 -> 0, then matches normally.
REQ-022 IRQ_CLR clears pending of wr_ch; clear and match in the same cycle -> pending stays 1 (set wins).
REQ-023 irq rises exactly one clk edge after the tick cycle in which the match occurs; no combinational path from wr_* to irq.
REQ-024 Writes with wr_ch >= NCH have no effect.
REQ-025 Channels independent: write to one channel never alters another channel's state.

Reset
REQ-026 rst clears all counts, cmp, enable, mode, pending, psc_div, and prescaler counter to 0; irq=0, irq_any=0 in the cycle after rst.
REQ-027 rst takes priority over writes and ticks in the same cycle; rst mid-count discards progress.

Structure
REQ-028 Package prog_timer_pkg holds wr_sel enum (CMP, CTRL, IRQ_CLR, PSC) and mode enum (PERIODIC, ONESHOT).
REQ-029 Sub-module timer_channel (count, cmp, enable, mode, pending) instantiated NCH times via generate; prescaler remains in prog_timer.

Verification
REQ-030 psc=0, ch0 cmp=3, CTRL=periodic enable -> irq[0] rises at 4 cycles after enable, count sequence 0,1,2,3,0.
REQ-031 psc=2, ch1 cmp=1, one-shot -> single irq[1] 6 cycles after enable, enable cleared, count stays 0.
REQ-032 ch0 running at count=10, write cmp=5 (WIDTH=4) -> count wraps 15->0, match at 5.
REQ-033 IRQ_CLR on ch2 in same cycle as ch2 match -> irq[2] remains 1; clear next cycle -> irq[2]=0.
REQ-034 All NCH channels enabled, distinct cmp values -> each irq bit at its own period; irq_any = OR; rst mid-run -> all outputs 0 next cycle.
